// File: rtl/rx_pkg.sv
// Shared types and constants for the Manchester-style receive path.
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        RECEIVE
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD0;
    localparam int         NUM_SAMP      = 16;

endpackage

// File: rtl/rx_idle_timer.sv
// Counts sample strobes since the last clear; term flags the idle threshold.
// The count holds at the threshold until cleared.
module rx_idle_timer #(
    parameter int IDLE_SAMPLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic samp_en,
    input  logic clr,
    output logic term
);

    localparam int CW = $clog2(IDLE_SAMPLES + 1);

    logic [CW-1:0] idle_cnt;

    assign term = (idle_cnt == CW'(IDLE_SAMPLES));

    // Strobe counter: clear wins, otherwise count up and hold at the threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (clr) begin
            idle_cnt <= '0;
        end else if (samp_en && !term) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// Assembles decided bits into bytes, hunts preamble + SFD, and hands payload
// bytes out over valid/ready with carrier, end-of-frame and error flags.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HUNT    | shifting every bit, waiting for the shift register to read PREAMBLE
// SYNC    | byte-aligned, counting preamble bytes until a qualified SFD
// RECEIVE | payload bytes delivered to the consumer until the line goes idle
module rx_frame_assembler
    import rx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] PREAMBLE     = DATA_W'(PREAMBLE_BYTE),
    parameter logic [DATA_W-1:0] SFD          = DATA_W'(SFD_BYTE),
    parameter int                PRE_BYTES    = 2,
    parameter int                IDLE_SAMPLES = 2 * NUM_SAMP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              samp_en,
    input  logic              write_0,
    input  logic              write_1,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              cardet,
    output logic              eof,
    output logic              error
);

    localparam int            BW   = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    rx_state_t         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted, data_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [2:0]        pre_cnt, pre_cnt_n;
    logic              valid_n, cardet_n, eof_n, error_n;
    logic              bit_evt, conflict, idle_clr, idle_term;

    assign bit_evt  = write_0 ^ write_1;
    assign conflict = write_0 & write_1;
    assign shifted  = {write_1, shreg[DATA_W-1:1]};
    // Any bit activity, even a conflicting one, proves the line is not idle.
    assign idle_clr = (state == HUNT) || write_0 || write_1;

    rx_idle_timer #(
        .IDLE_SAMPLES(IDLE_SAMPLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .samp_en (samp_en),
        .clr     (idle_clr),
        .term    (idle_term)
    );

    // Next-state and next-output decode for the whole frame pipeline.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        pre_cnt_n = pre_cnt;
        data_n    = data;
        valid_n   = valid && !ready;
        cardet_n  = cardet;
        eof_n     = 1'b0;
        error_n   = error;

        if (bit_evt) begin
            shreg_n = shifted;
        end

        unique case (state)
            HUNT: begin
                if (bit_evt && shifted == PREAMBLE) begin
                    state_n   = SYNC;
                    pre_cnt_n = 3'd1;
                    bit_cnt_n = '0;
                    cardet_n  = 1'b1;
                    error_n   = 1'b0;
                end
            end
            SYNC, RECEIVE: begin
                if (conflict) begin
                    state_n  = HUNT;
                    cardet_n = 1'b0;
                    shreg_n  = '0;
                    error_n  = 1'b1;
                end else if (bit_evt) begin
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == LAST) begin
                        if (state == SYNC) begin
                            if (shifted == PREAMBLE) begin
                                if (pre_cnt != 3'd7) pre_cnt_n = pre_cnt + 3'd1;
                            end else if (shifted == SFD && pre_cnt >= 3'(PRE_BYTES)) begin
                                state_n = RECEIVE;
                            end else begin
                                // Not a preamble continuation: drop quietly and
                                // restart the hunt from a clean, bit-aligned register.
                                state_n  = HUNT;
                                cardet_n = 1'b0;
                                shreg_n  = '0;
                            end
                        end else if (valid && !ready) begin
                            error_n = 1'b1;
                        end else begin
                            data_n  = shifted;
                            valid_n = 1'b1;
                        end
                    end
                end else if (idle_term) begin
                    state_n  = HUNT;
                    cardet_n = 1'b0;
                    shreg_n  = '0;
                    if (state == RECEIVE && bit_cnt == '0) eof_n   = 1'b1;
                    else                                   error_n = 1'b1;
                end
            end
            default: begin
                state_n  = HUNT;
                cardet_n = 1'b0;
                shreg_n  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HUNT;
            shreg   <= '0;
            bit_cnt <= '0;
            pre_cnt <= '0;
            data    <= '0;
            valid   <= 1'b0;
            cardet  <= 1'b0;
            eof     <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            pre_cnt <= pre_cnt_n;
            data    <= data_n;
            valid   <= valid_n;
            cardet  <= cardet_n;
            eof     <= eof_n;
            error   <= error_n;
        end
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler: directed frames plus random traffic
// against a bit-level behavioural model of the receiver.
module tb_rx_frame_assembler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       samp_en = 1'b0;
    logic       write_0 = 1'b0;
    logic       write_1 = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, cardet, eof, error;

    int n_checks = 0;
    int n_err    = 0;

    rx_frame_assembler dut (
        .clk     (clk),
        .reset   (reset),
        .samp_en (samp_en),
        .write_0 (write_0),
        .write_1 (write_1),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .cardet  (cardet),
        .eof     (eof),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 hunting, 1 counting preamble bytes, 2 delivering payload
    int m_mode = 0, m_sh = 0, m_nb = 0, m_pre = 0, m_idle = 0;
    int exp_data = 0, exp_valid = 0, exp_cardet = 0, exp_eof = 0, exp_err = 0;

    function automatic void model_drop();
        m_mode     = 0;
        exp_cardet = 0;
        m_sh       = 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_mode = 0; m_sh = 0; m_nb = 0; m_pre = 0; m_idle = 0;
                exp_data = 0; exp_valid = 0; exp_cardet = 0; exp_eof = 0; exp_err = 0;
            end else begin
                int  old_valid;
                bit  ev, conf;
                ev        = (write_0 != write_1);
                conf      = write_0 && write_1;
                old_valid = exp_valid;
                exp_eof   = 0;
                if (old_valid == 1 && ready) exp_valid = 0;
                if (m_mode == 0) begin
                    if (ev) begin
                        m_sh = (m_sh >> 1) | (int'(write_1) << 7);
                        if (m_sh == 'h55) begin
                            m_mode = 1; m_pre = 1; m_nb = 0; m_idle = 0;
                            exp_cardet = 1; exp_err = 0;
                        end
                    end
                end else if (conf) begin
                    model_drop();
                    exp_err = 1;
                    m_idle  = 0;
                end else if (ev) begin
                    m_idle = 0;
                    m_sh   = (m_sh >> 1) | (int'(write_1) << 7);
                    m_nb   = m_nb + 1;
                    if (m_nb == 8) begin
                        m_nb = 0;
                        if (m_mode == 1) begin
                            if (m_sh == 'h55) m_pre = (m_pre < 7) ? m_pre + 1 : 7;
                            else if (m_sh == 'hD0 && m_pre >= 2) m_mode = 2;
                            else model_drop();
                        end else if (old_valid == 1 && !ready) begin
                            exp_err = 1;
                        end else begin
                            exp_data  = m_sh;
                            exp_valid = 1;
                        end
                    end
                end else if (m_idle == 32) begin
                    if (m_mode == 2 && m_nb == 0) exp_eof = 1;
                    else                          exp_err = 1;
                    model_drop();
                    m_idle = 0;
                end else if (samp_en) begin
                    m_idle = m_idle + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [7:0] acc_q[$];
    int         eof_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("data",   32'(data),   32'(exp_data));
            chk("valid",  32'(valid),  32'(exp_valid));
            chk("cardet", 32'(cardet), 32'(exp_cardet));
            chk("eof",    32'(eof),    32'(exp_eof));
            chk("error",  32'(error),  32'(exp_err));
            if (valid && ready) acc_q.push_back(data);
            if (eof) eof_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 0;

    task automatic cyc(input logic w0, input logic w1, input logic s);
        write_0 = w0;
        write_1 = w1;
        samp_en = s;
        if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        write_0 = 1'b0;
        write_1 = 1'b0;
        samp_en = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int gap;
        cyc(!b, b, 1'($urandom_range(0, 1)));
        gap = $urandom_range(0, 3);
        repeat (gap) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic go_idle();
        repeat (40) cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        ready = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pre;
        pre = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data",  32'(data),  0);
        reset = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Clean frame, consumer always ready.
        acc_q.delete(); eof_cnt = 0;
        for (int i = 0; i < 7; i++) send_bit(pre[i]);
        chk("t1_cardet_before", 32'(cardet), 0);
        send_bit(pre[7]);
        chk("t1_cardet_after", 32'(cardet), 1);
        send_byte(8'h55); send_byte(8'hD0); send_byte(8'hA5); send_byte(8'h3C);
        go_idle();
        chk("t1_nbytes", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            chk("t1_byte0", 32'(acc_q[0]), 32'hA5);
            chk("t1_byte1", 32'(acc_q[1]), 32'h3C);
        end
        chk("t1_eof", eof_cnt, 1);
        chk("t1_error", 32'(error), 0);
        chk("t1_cardet_end", 32'(cardet), 0);

        // Same frame with the consumer stalled: second byte overruns.
        acc_q.delete(); eof_cnt = 0;
        ready = 1'b0;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD0); send_byte(8'hA5);
        send_byte(8'h3C);
        chk("t2_data", 32'(data), 32'hA5);
        chk("t2_valid", 32'(valid), 1);
        chk("t2_error", 32'(error), 1);
        go_idle();
        drain();
        chk("t2_nbytes", acc_q.size(), 1);

        // Single preamble byte before SFD: frame rejected silently.
        acc_q.delete(); eof_cnt = 0;
        send_byte(8'h55); send_byte(8'hD0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t3_cardet", 32'(cardet), 0);
        chk("t3_error", 32'(error), 0);
        chk("t3_nbytes", acc_q.size(), 0);

        // Partial trailing byte at idle: error, no eof.
        acc_q.delete(); eof_cnt = 0;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD0); send_byte(8'hA5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        go_idle();
        chk("t4_nbytes", acc_q.size(), 1);
        chk("t4_eof", eof_cnt, 0);
        chk("t4_error", 32'(error), 1);

        // Conflicting bit decision mid-payload, then a recovering frame.
        acc_q.delete(); eof_cnt = 0;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD0); send_byte(8'hA5);
        send_bit(1'b0); send_bit(1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t5_error", 32'(error), 1);
        chk("t5_cardet", 32'(cardet), 0);
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD0); send_byte(8'h0F);
        go_idle();
        chk("t5_error_clr", 32'(error), 0);
        chk("t5_nbytes", acc_q.size(), 2);
        if (acc_q.size() >= 2) chk("t5_last", 32'(acc_q[1]), 32'h0F);

        // Asynchronous reset in the middle of a payload.
        ready = 1'b0;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD0); send_byte(8'hA5);
        send_byte(8'h3C); send_bit(1'b1);
        chk("t6_valid_pre", 32'(valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 0);
        chk("t6_cardet", 32'(cardet), 0);
        chk("t6_error", 32'(error), 0);
        chk("t6_eof", 32'(eof), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        ready = 1'b1;

        // Random traffic: noise, variable preamble, sometimes bad SFD,
        // random stalls, occasional conflicts and partial tails.
        rnd_ready = 1;
        for (int f = 0; f < 60; f++) begin
            int npre, nbytes, nnoise, ntail;
            nnoise = $urandom_range(0, 10);
            for (int i = 0; i < nnoise; i++) send_bit(1'($urandom_range(0, 1)));
            npre = $urandom_range(1, 3);
            for (int i = 0; i < npre; i++) send_byte(8'h55);
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom_range(0, 255)));
            else                           send_byte(8'hD0);
            nbytes = $urandom_range(0, 4);
            for (int i = 0; i < nbytes; i++) send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) cyc(1'b1, 1'b1, 1'b0);
            ntail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < ntail; i++) send_bit(1'($urandom_range(0, 1)));
            go_idle();
        end
        rnd_ready = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
